// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-N baud generator with oversample, mid-bit and
// bit-boundary ticks, shadowed divisor and IDLE/RUN control.
//
// Ports:
//   i_Clock     clock, rising edge
//   i_reset     async active-low reset
//   i_enable    run request (low = idle)
//   i_div_int   integer divisor, clocks per oversample tick
//   i_div_frac  fractional divisor, units of 1/2^FRAC_W
//   i_load      captures i_div_int/i_div_frac into the shadow register
//   o_os_tick   oversample tick pulse
//   o_mid_tick  mid-bit pulse (RX sample point)
//   o_bit_tick  bit-boundary pulse
//   o_phase     oversample phase within the bit
//   o_cfg_err   active integer divisor is zero
module baud_gen_frac #(
  parameter int DIV_W     = 16,
  parameter int FRAC_W    = 4,
  parameter int OSR       = 16,
  parameter int RESET_DIV = 27
) (
  input  logic                    i_Clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [DIV_W-1:0]        i_div_int,
  input  logic [FRAC_W-1:0]       i_div_frac,
  input  logic                    i_load,
  output logic                    o_os_tick,
  output logic                    o_mid_tick,
  output logic                    o_bit_tick,
  output logic [$clog2(OSR)-1:0]  o_phase,
  output logic                    o_cfg_err
);

  localparam int PH_W = $clog2(OSR);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  act_int, sh_int, nxt_int;
  logic [FRAC_W-1:0] act_frac, sh_frac, nxt_frac;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [PH_W-1:0]   phase;
  logic [DIV_W:0]    last;
  logic [FRAC_W:0]   sum;
  logic              running;
  logic              tick_evt;
  logic              upd_act;
  logic              os_q, mid_q, bit_q, err_q;

  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (i_enable)  state_n = RUN;
      RUN:  if (!i_enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // last = P-1; a zero divisor behaves as one
  always_comb begin
    if (act_int == '0)
      last = {{DIV_W{1'b0}}, carry};
    else
      last = {1'b0, act_int} - (DIV_W+1)'(1)
           + {{DIV_W{1'b0}}, carry};
  end

  // a falling enable wins over a coincident wrap
  assign running  = (state == RUN) && i_enable;
  assign tick_evt = running && ({1'b0, cnt} == last);
  assign upd_act  = (state == IDLE) || tick_evt;

  // a load on the transfer edge bypasses the shadow
  assign nxt_int  = i_load ? i_div_int  : sh_int;
  assign nxt_frac = i_load ? i_div_frac : sh_frac;
  assign sum      = {1'b0, acc} + {1'b0, act_frac};

  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      phase    <= '0;
      act_int  <= DIV_W'(RESET_DIV);
      act_frac <= '0;
      sh_int   <= DIV_W'(RESET_DIV);
      sh_frac  <= '0;
      os_q     <= 1'b0;
      mid_q    <= 1'b0;
      bit_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      os_q  <= 1'b0;
      mid_q <= 1'b0;
      bit_q <= 1'b0;
      err_q <= (act_int == '0);
      if (i_load) begin
        sh_int  <= i_div_int;
        sh_frac <= i_div_frac;
      end
      if (upd_act) begin
        act_int  <= nxt_int;
        act_frac <= nxt_frac;
      end
      if (!running) begin
        cnt   <= '0;
        acc   <= '0;
        carry <= 1'b0;
        phase <= '0;
      end else if (tick_evt) begin
        cnt          <= '0;
        {carry, acc} <= sum;
        phase        <= phase + PH_W'(1);
        os_q         <= 1'b1;
        bit_q        <= (phase == PH_W'(OSR-1));
        mid_q        <= (phase == PH_W'(OSR/2-1));
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  assign o_os_tick  = os_q;
  assign o_mid_tick = mid_q;
  assign o_bit_tick = bit_q;
  assign o_phase    = phase;
  assign o_cfg_err  = err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: deadline-based reference model, per-cycle compare,
// directed interval checks and randomized divisor/enable traffic.
module tb_baud_gen_frac;

  localparam int DW  = 16;
  localparam int FW  = 4;
  localparam int OSR = 16;
  localparam int PW  = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          load  = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [FW-1:0] fin   = '0;
  logic          os, mid, bt, err;
  logic [PW-1:0] ph;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0     = 0;
  int n0     = 0;
  int os_q[$];
  int bit_q[$];
  int mid_q[$];

  always #5 clk = ~clk;

  baud_gen_frac dut (
    .i_Clock   (clk),
    .i_reset   (rst_n),
    .i_enable  (en),
    .i_div_int (din),
    .i_div_frac(fin),
    .i_load    (load),
    .o_os_tick (os),
    .o_mid_tick(mid),
    .o_bit_tick(bt),
    .o_phase   (ph),
    .o_cfg_err (err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // model: absolute deadline of next tick, tick count mod OSR
  int mcyc    = 0;
  int t_next  = 0;
  int m_acc   = 0;
  int m_carry = 0;
  int m_ticks = 0;
  int a_int   = 27;
  int a_frac  = 0;
  int s_int   = 27;
  int s_frac  = 0;
  bit m_run   = 0;
  bit e_os    = 0;
  bit e_mid   = 0;
  bit e_bit   = 0;
  bit e_err   = 0;

  function automatic int eff(int d);
    return (d == 0) ? 1 : d;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int now, ni, nf, sum, k;
    if (!rst_n) begin
      m_run   <= 0;
      m_acc   <= 0;
      m_carry <= 0;
      m_ticks <= 0;
      a_int   <= 27;
      a_frac  <= 0;
      s_int   <= 27;
      s_frac  <= 0;
      e_os    <= 0;
      e_mid   <= 0;
      e_bit   <= 0;
      e_err   <= 0;
    end else begin
      now = mcyc + 1;
      mcyc  <= now;
      e_os  <= 0;
      e_mid <= 0;
      e_bit <= 0;
      e_err <= (a_int == 0);
      ni = load ? int'(din) : s_int;
      nf = load ? int'(fin) : s_frac;
      if (load) begin
        s_int  <= int'(din);
        s_frac <= int'(fin);
      end
      if (!m_run) begin
        a_int  <= ni;
        a_frac <= nf;
        if (en) begin
          m_run  <= 1;
          t_next <= now + eff(ni);
        end
      end else if (!en) begin
        m_run   <= 0;
        m_acc   <= 0;
        m_carry <= 0;
        m_ticks <= 0;
      end else if (now == t_next) begin
        sum = m_acc + a_frac;
        k   = (m_ticks + 1) % OSR;
        m_ticks <= k;
        e_os    <= 1;
        e_bit   <= (k == 0);
        e_mid   <= (k == OSR/2);
        m_acc   <= sum % (1 << FW);
        m_carry <= sum / (1 << FW);
        a_int   <= ni;
        a_frac  <= nf;
        t_next  <= now + eff(ni) + sum / (1 << FW);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (os)  os_q.push_back(cyc);
    if (bt)  bit_q.push_back(cyc);
    if (mid) mid_q.push_back(cyc);
    check("os_tick",  32'(os),  32'(e_os));
    check("mid_tick", 32'(mid), 32'(e_mid));
    check("bit_tick", 32'(bt),  32'(e_bit));
    check("phase",    32'(ph),  32'(m_ticks));
    check("cfg_err",  32'(err), 32'(e_err));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr_q();
    os_q.delete();
    bit_q.delete();
    mid_q.delete();
  endtask

  task automatic wait_os(input int n, input int lim);
    int k;
    k = 0;
    while (os_q.size() < n && k < lim) begin
      step(1);
      k++;
    end
    if (os_q.size() < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_os: got %0d ticks expected %0d",
               os_q.size(), n);
    end
  endtask

  task automatic start(input int d, input int f);
    en   = 1'b0;
    din  = DW'(d);
    fin  = FW'(f);
    load = 1'b1;
    step(1);
    load = 1'b0;
    en   = 1'b1;
    t0   = cyc;
    clr_q();
  endtask

  initial begin
    step(3);
    check("rst_os",  32'(os),  0);
    check("rst_ph",  32'(ph),  0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    step(2);

    start(4, 0);
    wait_os(34, 400);
    check("div4_first", os_q[0] - t0 - 1, 4);
    check("div4_int",   os_q[5] - os_q[4], 4);
    check("bit_first",  bit_q[0] - t0 - 1, 64);
    check("bit_period", bit_q[1] - bit_q[0], 64);
    check("mid_after",  mid_q[1] - bit_q[0], 32);

    start(4, 8);
    wait_os(16, 200);
    check("frac_i0",   os_q[0] - t0 - 1, 4);
    check("frac_i1",   os_q[1] - os_q[0], 4);
    check("frac_i2",   os_q[2] - os_q[1], 5);
    check("frac_i3",   os_q[3] - os_q[2], 4);
    check("frac_i4",   os_q[4] - os_q[3], 5);
    check("frac_span", os_q[15] - t0 - 1, 71);

    start(4, 0);
    wait_os(2, 50);
    din  = 16'd10;
    load = 1'b1;
    step(1);
    load = 1'b0;
    wait_os(4, 100);
    check("ld_cur",  os_q[2] - os_q[1], 4);
    check("ld_next", os_q[3] - os_q[2], 10);

    en = 1'b0;
    step(2);
    din  = '0;
    load = 1'b1;
    step(1);
    load = 1'b0;
    check("err_lag", 32'(err), 0);
    step(1);
    check("err_set", 32'(err), 1);
    en = 1'b1;
    t0 = cyc;
    clr_q();
    wait_os(6, 50);
    check("div0_first", os_q[0] - t0 - 1, 1);
    check("div0_int",   os_q[5] - os_q[4], 1);

    start(4, 0);
    begin
      int k;
      k = 0;
      while (ph != 4'd7 && k < 200) begin
        step(1);
        k++;
      end
    end
    check("ph7_seen", 32'(ph), 7);
    en = 1'b0;
    n0 = os_q.size();
    step(6);
    check("idle_notick", os_q.size(), n0);
    check("idle_ph0",    32'(ph), 0);
    en = 1'b1;
    t0 = cyc;
    wait_os(n0 + 1, 50);
    check("reen_first", os_q[n0] - t0 - 1, 4);
    check("reen_ph1",   32'(ph), 1);

    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en = ~en;
      load = ($urandom_range(0, 15) == 0);
      din  = DW'($urandom_range(0, 7));
      fin  = FW'($urandom_range(0, 15));
      step(1);
    end
    load = 1'b0;

    start(5, 8);
    step(30);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("arst_os",  32'(os),  0);
    check("arst_mid", 32'(mid), 0);
    check("arst_bit", 32'(bt),  0);
    check("arst_ph",  32'(ph),  0);
    check("arst_err", 32'(err), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    en = 1'b1;
    t0 = cyc;
    clr_q();
    wait_os(2, 100);
    check("post_rst_i0", os_q[0] - t0 - 1, 27);
    check("post_rst_i1", os_q[1] - os_q[0], 27);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
